seq_div: RTL and testbench

Sequential restoring integer divider: the inverse of the combinational multiplier example. It divides a DIVIDEND_W-bit unsigned dividend by a DIVISOR_W-bit unsigned divisor, producing one quotient bit per clock. Results are a full-width quotient and a remainder. It sits in the examples set as the clocked counterpart to multiplication, with a start/busy/done handshake that a testbench or enclosing FSM can drive.

---
 rtl/seq_div_pkg.sv | 16 +
 rtl/seq_div_step.sv | 34 +++
 rtl/seq_div.sv | 114 +++++++++++
 tb/tb_seq_div.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and the width helper for the step counter.
package seq_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to hold a step count from 0 up to and including n.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep or restore the result.
module div_step #(
    parameter int DIVISOR_W = 3
) (
    input  logic [DIVISOR_W:0]   prem,
    input  logic                 din,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   prem_next,
    output logic                 qbit
);

    logic [DIVISOR_W+1:0] shifted_s;
    logic [DIVISOR_W+1:0] diff_s;
    logic                 borrow_s;

    // The partial remainder is always below the divisor, so the shifted value
    // fits in DIVISOR_W+1 bits and the extra top bit of the difference is the borrow.
    always_comb begin
        shifted_s = {prem, din};
        diff_s    = shifted_s - {2'b00, divisor};
        borrow_s  = diff_s[DIVISOR_W+1];
        prem_next = '0;
        qbit      = 1'b0;
        if (borrow_s) begin
            prem_next = shifted_s[DIVISOR_W:0];
            qbit      = 1'b0;
        end else begin
            prem_next = diff_s[DIVISOR_W:0];
            qbit      = 1'b1;
        end
    end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring unsigned divider, one quotient bit per clock, with a
// start/busy/done handshake. The dividend register shifts out its MSB each
// step and shifts in the new quotient bit, so it ends up holding the quotient.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int DIVIDEND_W = 6,
    parameter int DIVISOR_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder
);

    localparam int CNT_W = count_width(DIVIDEND_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

    state_t                state_r;
    logic [CNT_W-1:0]      count_r;
    logic [DIVISOR_W:0]    prem_r;
    logic [DIVIDEND_W-1:0] work_r;
    logic [DIVISOR_W-1:0]  dsr_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  dbz_r;

    logic [DIVISOR_W:0]    step_prem_s;
    logic                  step_q_s;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .prem      (prem_r),
        .din       (work_r[DIVIDEND_W-1]),
        .divisor   (dsr_r),
        .prem_next (step_prem_s),
        .qbit      (step_q_s)
    );

    // Control FSM plus datapath registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            count_r <= '0;
            prem_r  <= '0;
            work_r  <= '0;
            dsr_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        count_r <= '0;
                        prem_r  <= '0;
                        dsr_r   <= divisor;
                        if (divisor == {DIVISOR_W{1'b0}}) begin
                            // Zero divisor finishes at once with saturated quotient.
                            state_r <= ST_DONE;
                            work_r  <= {DIVIDEND_W{1'b1}};
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            dbz_r   <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            work_r  <= dividend;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                            dbz_r   <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    prem_r  <= step_prem_s;
                    work_r  <= {work_r[DIVIDEND_W-2:0], step_q_s};
                    count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (count_r == LAST_STEP) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign quotient    = work_r;
    assign remainder   = prem_r[DIVISOR_W-1:0];

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed cases plus a shuffled sweep of
// every operand pair, checked against plain integer division.
module tb_seq_div;

    localparam int DW   = 6;
    localparam int SW   = 3;
    localparam int QMAX = (1 << DW) - 1;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [DW-1:0] dividend;
    logic [SW-1:0] divisor;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;

    int n_checks = 0;
    int n_pass   = 0;

    seq_div #(
        .DIVIDEND_W (DW),
        .DIVISOR_W  (SW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Present operands with start for one edge (E0); returns #1 after E0.
    task automatic launch(input int a, input int b);
        dividend = DW'(a);
        divisor  = SW'(b);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges (E0 is edge 1) until done is seen, with a bounded wait.
    task automatic wait_done(input int e_start, input bit b_start, output int edges, output bit saw_busy);
        edges    = e_start;
        saw_busy = b_start | busy;
        while (!done && edges < 4 * DW) begin
            @(posedge clk);
            #1;
            edges++;
            saw_busy = saw_busy | busy;
        end
    endtask

    // Compare the done cycle against the arithmetic model.
    task automatic expect_result(input string tag, input int a, input int b, input int edges, input bit saw_busy);
        int exp_q, exp_r, exp_lat;
        if (b == 0) begin
            exp_q = QMAX; exp_r = 0; exp_lat = 1;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_lat = DW + 1;
        end
        check({tag, "_latency"}, edges, exp_lat);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy_in_done"}, 32'(busy), 0);
        check({tag, "_quot"}, 32'(quotient), exp_q);
        check({tag, "_rem"}, 32'(remainder), exp_r);
        check({tag, "_dbz"}, 32'(div_by_zero), (b == 0) ? 1 : 0);
        check({tag, "_saw_busy"}, 32'(saw_busy), (b != 0) ? 1 : 0);
    endtask

    task automatic run_one(input string tag, input int a, input int b);
        int edges;
        bit sb;
        launch(a, b);
        wait_done(1, 1'b0, edges, sb);
        expect_result(tag, a, b, edges, sb);
    endtask

    // Step one edge with start low and confirm done was a single-cycle pulse.
    task automatic idle_cycle(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, 32'(done), 0);
    endtask

    initial begin
        int edges;
        bit sb;
        int mult, off, idx, a, b;
        int mults[6] = '{1, 3, 5, 9, 11, 13};

        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        check("rst_quot", 32'(quotient), 0);
        check("rst_rem", 32'(remainder), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run_one("d42_6", 42, 6);
        idle_cycle("d42_6");

        run_one("d63_5", 63, 5);
        run_one("d63_1_b2b", 63, 1);
        idle_cycle("d63_1");

        run_one("d0_7", 0, 7);
        idle_cycle("d0_7");
        run_one("d5_7", 5, 7);
        idle_cycle("d5_7");
        run_one("d13_0", 13, 0);
        idle_cycle("d13_0");

        // Start pulsed during the third busy cycle must be ignored.
        launch(42, 6);
        check("ign_busy1", 32'(busy), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        dividend = 6'd9;
        divisor  = 3'd2;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(4, 1'b1, edges, sb);
        expect_result("ign", 42, 6, edges, sb);
        idle_cycle("ign");

        // Reset during the fourth busy cycle aborts without a done.
        launch(42, 6);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy_before", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_quot", 32'(quotient), 0);
        check("abort_rem", 32'(remainder), 0);
        check("abort_dbz", 32'(div_by_zero), 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_one("d20_3", 20, 3);
        idle_cycle("d20_3");

        // Every (dividend, nonzero divisor) pair in a random permutation,
        // with random back-to-back or idle gaps between divisions.
        mult = mults[$urandom_range(0, 5)];
        off  = $urandom_range(0, 447);
        for (int i = 0; i < 448; i++) begin
            idx = (i * mult + off) % 448;
            a   = idx / 7;
            b   = (idx % 7) + 1;
            launch(a, b);
            wait_done(1, 1'b0, edges, sb);
            expect_result("sweep", a, b, edges, sb);
            check("sweep_recon", 32'(int'(quotient) * b + int'(remainder)), a);
            check("sweep_rem_lt", 32'(int'(remainder) < b), 1);
            if ($urandom_range(0, 1) == 0) begin
                idle_cycle("sweep");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
